spi_slave_rx: RTL and testbench

//  SPI slave endpoint, mode 0 (CPOL=0, CPHA=0), MSB first. It is the far end of our SPI master shift path.

---
 rtl/spi_slave_rx.sv | 136 +++++++++++++
 tb/tb_spi_slave_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave endpoint: oversamples sclk/cs_n/mosi in the clk domain, deserialises MOSI into
// words handed off with a valid/ack handshake, and shifts a preloaded word out on MISO, MSB first.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_empty,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic sclk_prev_reg, cs_prev_reg;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [DATA_W-1:0] rx_shift_reg, tx_shift_reg, tx_buf_reg, rx_data_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              rx_valid_reg, overrun_reg, tx_empty_reg;
  logic              in_frame, do_reload;

  // cs_n synchronisers reset high so a select held low through reset is seen as a fresh falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      cs_sync_reg   <= '1;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = !sclk_prev_reg && sclk_s;
  assign sclk_fall = sclk_prev_reg && !sclk_s;
  assign cs_rise   = !cs_prev_reg && cs_s;
  assign cs_fall   = cs_prev_reg && !cs_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    miso = 1'b0;
    if (state_reg == ACTIVE) miso = tx_shift_reg[DATA_W-1];
  end

  // Deselect beats any sclk edge seen in the same cycle
  assign in_frame  = (state_reg == ACTIVE) && !cs_rise;
  assign do_reload = ((state_reg == IDLE) && cs_fall) ||
                     (in_frame && sclk_fall && (bit_cnt_reg == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift_reg <= '0;
      tx_shift_reg <= '0;
      tx_buf_reg   <= '0;
      rx_data_reg  <= '0;
      bit_cnt_reg  <= '0;
      rx_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      tx_empty_reg <= 1'b1;
    end else begin
      overrun_reg <= 1'b0;
      if (rx_ack) rx_valid_reg <= 1'b0;

      if ((state_reg == IDLE && cs_fall) || (state_reg == ACTIVE && cs_rise)) begin
        bit_cnt_reg <= '0;
      end else if (in_frame) begin
        if (sclk_rise) begin
          rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], mosi_s};
          if (bit_cnt_reg == LAST_BIT) begin
            rx_data_reg  <= {rx_shift_reg[DATA_W-2:0], mosi_s};
            rx_valid_reg <= 1'b1;
            overrun_reg  <= rx_valid_reg && !rx_ack;
            bit_cnt_reg  <= '0;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          end
        end
        if (sclk_fall && (bit_cnt_reg != '0)) tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
      end

      // A reload consumes the old buffer before a coincident load refills it
      if (do_reload) begin
        tx_shift_reg <= tx_empty_reg ? '0 : tx_buf_reg;
        tx_empty_reg <= 1'b1;
      end
      if (tx_load) begin
        tx_buf_reg   <= tx_data;
        tx_empty_reg <= 1'b0;
      end
    end
  end

  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign overrun  = overrun_reg;
  assign tx_empty = tx_empty_reg;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomised bench for spi_slave_rx: an SPI master drives frames, a word-level model predicts
// received words, overruns and MISO words; a monitor checks each delivered word against a queue.
module tb_spi_slave_rx;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst, sclk, cs_n, mosi, miso, tx_load, tx_empty, rx_valid, rx_ack, overrun;
  logic [7:0] tx_data, rx_data;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .overrun(overrun)
  );

  typedef struct {logic [7:0] data; logic ovr;} rx_exp_t;
  rx_exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Word-level model: one pending rx word flag, one tx buffer with a pending flag
  bit         model_rx_pending = 0;
  bit         model_tx_pending = 0;
  logic [7:0] model_tx_buf = '0;
  logic [7:0] model_tx_cur = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reload();
    model_tx_cur     = model_tx_pending ? model_tx_buf : 8'h00;
    model_tx_pending = 0;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    cyc(1);
    rx_ack = 1'b0;
    model_rx_pending = 0;
  endtask

  task automatic do_load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
    model_tx_buf = v;
    model_tx_pending = 1;
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    model_reload();
    cyc(HALF);
  endtask

  task automatic end_frame();
    cyc(HALF);
    cs_n = 1'b1;
    cyc(2 * HALF);
  endtask

  task automatic send_word(input logic [7:0] d, input int nbits, input bit ack_first,
                           input bit ack_last, input bit lat_chk, input int load_bit,
                           input logic [7:0] load_val);
    logic [7:0] got;
    logic [7:0] exp_miso;
    rx_exp_t    e;
    got = '0;
    exp_miso = model_tx_cur;
    if (ack_first) do_ack();
    for (int b = 0; b < nbits; b++) begin
      mosi = d[7-b];
      if (b == load_bit) begin
        do_load(load_val);
        cyc(HALF - 1);
      end else begin
        cyc(HALF);
      end
      sclk = 1'b1;
      got[7-b] = miso;
      if (b == 7) begin
        e.data = d;
        e.ovr  = ack_last ? 1'b0 : model_rx_pending;
        exp_q.push_back(e);
        model_rx_pending = 1;
        cyc(2);
        if (lat_chk) chk("latency_before", rx_valid, 1'b0);
        if (ack_last) rx_ack = 1'b1;
        cyc(1);
        rx_ack = 1'b0;
        if (lat_chk) chk("latency_at", rx_valid, 1'b1);
        cyc(1);
      end else begin
        cyc(HALF);
      end
      sclk = 1'b0;
    end
    if (nbits == 8) begin
      chk("miso_word", got, exp_miso);
      model_reload();
    end
  endtask

  // Monitor: a delivered word shows as an overrun pulse, a rising rx_valid, or new data under rx_valid
  logic       mon_pv = 1'b0;
  logic [7:0] mon_pd = '0;
  rx_exp_t    mon_e;
  always @(negedge clk) begin
    if (!rst && (overrun || (rx_valid && (!mon_pv || rx_data != mon_pd)))) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word got=%0h ovr=%0b expected=none", rx_data, overrun);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_data", rx_data, mon_e.data);
        chk("overrun", overrun, mon_e.ovr);
        chk("rx_valid", rx_valid, 1'b1);
      end
    end
    mon_pv = rx_valid;
    mon_pd = rx_data;
  end

  initial begin
    int nw;
    int ld;
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_load = 1'b0; tx_data = '0; rx_ack = 1'b0;
    cyc(3);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_tx_empty", tx_empty, 1'b1);
    chk("reset_miso", miso, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    rst = 1'b0;
    cyc(4);

    // 1: preloaded 0xA5 out, 0x3C in, latency check
    do_load(8'hA5);
    chk("tx_empty_after_load", tx_empty, 1'b0);
    start_frame();
    chk("tx_empty_after_reload", tx_empty, 1'b1);
    send_word(8'h3C, 8, 0, 0, 1, -1, 8'h00);
    end_frame();
    chk("idle_miso", miso, 1'b0);
    do_ack();

    // 2: back-to-back words with ack between, mid-frame load feeds the second word
    start_frame();
    send_word(8'h01, 8, 0, 0, 0, 3, 8'h6E);
    send_word(8'h80, 8, 1, 0, 0, -1, 8'h00);
    end_frame();
    do_ack();

    // 3: two words without ack -> one overrun
    start_frame();
    send_word(8'hAA, 8, 0, 0, 0, -1, 8'h00);
    send_word(8'h77, 8, 0, 0, 0, -1, 8'h00);
    end_frame();
    chk("ovr_rx_valid", rx_valid, 1'b1);
    chk("ovr_rx_data", rx_data, 8'h77);

    // 4: partial word discarded, then a full frame
    do_ack();
    start_frame();
    send_word(8'hFF, 5, 0, 0, 0, -1, 8'h00);
    cs_n = 1'b1;
    cyc(2 * HALF);
    chk("partial_no_valid", rx_valid, 1'b0);
    start_frame();
    send_word(8'h12, 8, 0, 0, 0, -1, 8'h00);
    end_frame();

    // 5: ack coincides with completion while 0x12 is still pending
    start_frame();
    send_word(8'h55, 8, 0, 1, 0, -1, 8'h00);
    end_frame();
    chk("coincide_rx_valid", rx_valid, 1'b1);
    chk("coincide_rx_data", rx_data, 8'h55);
    do_ack();

    // 6: reset mid-frame with cs_n held low, frame restarts from bit 0
    do_load(8'h99);
    start_frame();
    send_word(8'hF0, 4, 0, 0, 0, -1, 8'h00);
    rst = 1'b1;
    cyc(2);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_rx_valid", rx_valid, 1'b0);
    chk("midrst_tx_empty", tx_empty, 1'b1);
    chk("midrst_miso", miso, 1'b0);
    chk("midrst_overrun", overrun, 1'b0);
    model_rx_pending = 0;
    model_tx_pending = 0;
    rst = 1'b0;
    model_reload();
    cyc(HALF);
    send_word(8'hC3, 8, 0, 0, 0, -1, 8'h00);
    end_frame();
    chk("restart_rx_data", rx_data, 8'hC3);
    do_ack();

    // Random frames
    for (int f = 0; f < 25; f++) begin
      if ($urandom % 2) do_load(8'($urandom));
      start_frame();
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        ld = ($urandom % 2) ? $urandom_range(1, 5) : -1;
        send_word(8'($urandom), 8, bit'($urandom % 2), 0, 0, ld, 8'($urandom));
      end
      end_frame();
      if ($urandom % 2) do_ack();
    end

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) cyc(1);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
